gtp_rx_link_ctrl: RTL and testbench

GTP_RX_LINK_CTRL -- requirements
Module: gtp_rx_link_ctrl

---
 rtl/gtp_link_pkg.sv | 26 ++
 rtl/word_aligner_20b.sv | 52 +++++
 rtl/gtp_rx_link_ctrl.sv | 166 ++++++++++++++++
 tb/tb_gtp_rx_link_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gtp_link_pkg.sv
// Shared state encoding, default link constants and offset helper for the GTP RX link controller.
package gtp_link_pkg;

  typedef enum logic [2:0] {
    ST_RESET_WAIT = 3'd0,
    ST_SEARCH     = 3'd1,
    ST_VERIFY     = 3'd2,
    ST_LOCKED     = 3'd3,
    ST_RECOVER    = 3'd4
  } link_state_e;

  localparam logic [19:0] DEF_SYNC_PATTERN = 20'hF83E0;
  localparam int          DEF_LOCK_COUNT   = 64;
  localparam int          DEF_TIMEOUT      = 1 << 20;
  localparam int          DEF_RESET_PULSE  = 32;
  localparam int          DEF_SETTLE       = 16;

  localparam int          WORD_W           = 20;
  localparam logic [4:0]  OFFSET_LAST      = 5'd19;

  // Advance the alignment offset by one bit, wrapping 19 back to 0.
  function automatic logic [4:0] next_offset(input logic [4:0] off);
    return (off == OFFSET_LAST) ? 5'd0 : off + 5'd1;
  endfunction

endpackage

// File: rtl/word_aligner_20b.sv
// Two-word receive pipeline with a 40->20 barrel window and a registered aligned output.
module word_aligner_20b
  import gtp_link_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [19:0] data_i,
  input  logic [4:0]  offset_i,
  output logic [19:0] window_o,
  output logic [19:0] aligned_o
);

  logic [19:0] d1_q;
  logic [19:0] d2_q;
  logic [19:0] aligned_q;
  logic [39:0] pair_w;
  logic [19:0] cand_w [WORD_W];

  // Newest word sits in the upper half so window(o) = pair[o+19:o].
  assign pair_w = {d1_q, d2_q};

  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_cand
      assign cand_w[gi] = pair_w[gi + WORD_W - 1 : gi];
    end
  endgenerate

  // Select the candidate window; an out-of-range offset yields zero instead of X.
  always_comb begin
    window_o = '0;
    if (offset_i < 5'(WORD_W)) begin
      window_o = cand_w[offset_i];
    end
  end

  // Shift the raw words through the pipeline and register the aligned word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d1_q      <= '0;
      d2_q      <= '0;
      aligned_q <= '0;
    end else begin
      d1_q      <= data_i;
      d2_q      <= d1_q;
      aligned_q <= window_o;
    end
  end

  assign aligned_o = aligned_q;

endmodule

// File: rtl/gtp_rx_link_ctrl.sv
// RX word-alignment and link supervision: searches the bit offset of the sync word,
// verifies it, holds lock, and pulses a transceiver soft reset when search times out.
module gtp_rx_link_ctrl
  import gtp_link_pkg::*;
#(
  parameter logic [19:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
  parameter int          LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int          TIMEOUT      = DEF_TIMEOUT,
  parameter int          RESET_PULSE  = DEF_RESET_PULSE,
  parameter int          SETTLE       = DEF_SETTLE
)(
  input  logic        data_clk,
  input  logic        reset_n,
  input  logic        rx_system_reset,
  input  logic [19:0] rx_data,
  input  logic        realign_req,
  output logic [19:0] aligned_data,
  output logic        data_valid,
  output logic [4:0]  bit_offset,
  output logic [2:0]  link_state,
  output logic        gtp_soft_reset,
  output logic [7:0]  relock_count
);

  localparam int SETTLE_W = $clog2(SETTLE + 1);
  localparam int LOCK_W   = $clog2(LOCK_COUNT + 1);
  localparam int TMO_W    = $clog2(TIMEOUT);
  localparam int PULSE_W  = $clog2(RESET_PULSE + 1);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_COUNT - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RESET_PULSE - 1);

  link_state_e         state_q, state_d;
  logic [4:0]          offset_q, offset_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [LOCK_W-1:0]   match_q, match_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [PULSE_W-1:0]  pulse_q, pulse_d;
  logic [7:0]          relock_q, relock_d;
  logic                valid_q, soft_q;
  logic [19:0]         window_w;
  logic                hit_w;
  logic [7:0]          relock_inc_w;

  word_aligner_20b u_aligner (
    .clk_i     (data_clk),
    .rst_ni    (reset_n),
    .data_i    (rx_data),
    .offset_i  (offset_q),
    .window_o  (window_w),
    .aligned_o (aligned_data)
  );

  assign hit_w        = (window_w == SYNC_PATTERN);
  assign relock_inc_w = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;

  // Next-state logic; rx_system_reset outranks timeout, which outranks match/realign.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    settle_d = settle_q;
    match_d  = match_q;
    tmo_d    = tmo_q;
    pulse_d  = pulse_q;
    relock_d = relock_q;
    case (state_q)
      ST_RESET_WAIT: begin
        tmo_d   = '0;
        match_d = '0;
        if (rx_system_reset) begin
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SEARCH;
          offset_d = 5'd0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SEARCH, ST_VERIFY: begin
        if (rx_system_reset) begin
          state_d = ST_RESET_WAIT;
          tmo_d   = '0;
          match_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_RECOVER;
          tmo_d   = '0;
          match_d = '0;
          pulse_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (!hit_w) begin
            state_d  = ST_SEARCH;
            match_d  = '0;
            offset_d = next_offset(offset_q);
          end else if (state_q == ST_SEARCH && LOCK_COUNT > 1) begin
            state_d = ST_VERIFY;
            match_d = LOCK_W'(1);
          end else if (state_q == ST_SEARCH || match_q == LOCK_LAST) begin
            state_d = ST_LOCKED;
            tmo_d   = '0;
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (rx_system_reset) begin
          state_d  = ST_RESET_WAIT;
          relock_d = relock_inc_w;
        end else if (realign_req) begin
          state_d  = ST_SEARCH;
          offset_d = next_offset(offset_q);
          relock_d = relock_inc_w;
        end
      end
      ST_RECOVER: begin
        if (pulse_q == PULSE_LAST) begin
          state_d = ST_RESET_WAIT;
          pulse_d = '0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RESET_WAIT;
      end
    endcase
  end

  // State, counters and registered status flags; flags follow the next state so they
  // change in the same cycle as link_state.
  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RESET_WAIT;
      offset_q <= 5'd0;
      settle_q <= '0;
      match_q  <= '0;
      tmo_q    <= '0;
      pulse_q  <= '0;
      relock_q <= 8'd0;
      valid_q  <= 1'b0;
      soft_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      tmo_q    <= tmo_d;
      pulse_q  <= pulse_d;
      relock_q <= relock_d;
      valid_q  <= (state_d == ST_LOCKED);
      soft_q   <= (state_d == ST_RECOVER);
    end
  end

  assign data_valid     = valid_q;
  assign gtp_soft_reset = soft_q;
  assign bit_offset     = offset_q;
  assign link_state     = state_q;
  assign relock_count   = relock_q;

endmodule

// File: tb/tb_gtp_rx_link_ctrl.sv
// Self-checking bench: random and directed stimulus against a cycle reference model.
module tb_gtp_rx_link_ctrl;

  localparam logic [19:0] SYNC   = 20'hF83E0;
  localparam int          LOCKN  = 64;
  localparam int          TMO    = 1000;
  localparam int          PULSE  = 32;
  localparam int          SETTLE = 16;

  logic        data_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_system_reset = 1'b1;
  logic        realign_req = 1'b0;
  logic [19:0] rx_data = 20'd0;
  logic [19:0] aligned_data;
  logic        data_valid;
  logic [4:0]  bit_offset;
  logic [2:0]  link_state;
  logic        gtp_soft_reset;
  logic [7:0]  relock_count;

  int checks = 0;
  int errors = 0;

  // Reference model: state as a small integer, counters count "cycles so far".
  int          m_state, m_off, m_cnt, m_time, m_settle, m_pulse, m_relock;
  logic [19:0] m_d1, m_d2, m_aligned;

  gtp_rx_link_ctrl #(
    .SYNC_PATTERN (SYNC),
    .LOCK_COUNT   (LOCKN),
    .TIMEOUT      (TMO),
    .RESET_PULSE  (PULSE),
    .SETTLE       (SETTLE)
  ) dut (
    .data_clk        (data_clk),
    .reset_n         (reset_n),
    .rx_system_reset (rx_system_reset),
    .rx_data         (rx_data),
    .realign_req     (realign_req),
    .aligned_data    (aligned_data),
    .data_valid      (data_valid),
    .bit_offset      (bit_offset),
    .link_state      (link_state),
    .gtp_soft_reset  (gtp_soft_reset),
    .relock_count    (relock_count)
  );

  always #5 data_clk = ~data_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] win(input logic [19:0] hi, input logic [19:0] lo, input int o);
    logic [39:0] pair;
    pair = {hi, lo};
    return 20'(pair >> o);
  endfunction

  task automatic model_reset();
    m_state = 0; m_off = 0; m_cnt = 0; m_time = 0; m_settle = 0; m_pulse = 0; m_relock = 0;
    m_d1 = '0; m_d2 = '0; m_aligned = '0;
  endtask

  task automatic model_step(input logic [19:0] rx, input logic sys, input logic rea);
    logic [19:0] w;
    bit hit;
    w = win(m_d1, m_d2, m_off);
    hit = (w == SYNC);
    m_aligned = w;
    m_d2 = m_d1;
    m_d1 = rx;
    case (m_state)
      0: begin
        m_time = 0;
        if (sys) m_settle = 0;
        else begin
          m_settle++;
          if (m_settle == SETTLE) begin m_settle = 0; m_state = 1; m_off = 0; end
        end
      end
      1, 2: begin
        if (sys) begin m_state = 0; m_time = 0; m_cnt = 0; end
        else begin
          m_time++;
          if (m_time == TMO) begin m_state = 4; m_time = 0; m_pulse = 0; m_cnt = 0; end
          else if (hit) begin
            m_cnt = (m_state == 1) ? 1 : m_cnt + 1;
            if (m_cnt == LOCKN) begin m_state = 3; m_time = 0; m_cnt = 0; end
            else m_state = 2;
          end else begin
            m_state = 1; m_cnt = 0; m_off = (m_off + 1) % 20;
          end
        end
      end
      3: begin
        if (sys) begin m_state = 0; m_relock = (m_relock < 255) ? m_relock + 1 : 255; end
        else if (rea) begin
          m_state = 1; m_off = (m_off + 1) % 20;
          m_relock = (m_relock < 255) ? m_relock + 1 : 255;
        end
      end
      default: begin
        m_pulse++;
        if (m_pulse == PULSE) begin m_state = 0; m_pulse = 0; end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("link_state", link_state, m_state);
    chk("bit_offset", bit_offset, m_off);
    chk("data_valid", data_valid, (m_state == 3) ? 1 : 0);
    chk("gtp_soft_reset", gtp_soft_reset, (m_state == 4) ? 1 : 0);
    chk("relock_count", relock_count, m_relock);
    chk("aligned_data", aligned_data, m_aligned);
  endtask

  // One clock: drive inputs just after the falling edge, step the model, check at the next falling edge.
  task automatic cyc(input logic [19:0] rx, input logic sys, input logic rea);
    rx_data = rx;
    rx_system_reset = sys;
    realign_req = rea;
    model_step(rx, sys, rea);
    @(negedge data_clk);
    compare_all();
  endtask

  initial begin
    logic [19:0] sync_v, w7;
    int n, hi;
    sync_v = SYNC;
    w7 = (sync_v << 7) | (sync_v >> 13);
    model_reset();
    repeat (3) @(negedge data_clk);
    compare_all();
    reset_n = 1'b1;

    // Scenario 1: sync word skewed by 7 bits.
    repeat (4) cyc(w7, 1'b1, 1'b0);
    n = 0;
    while (link_state != 3'd3 && n < 400) begin cyc(w7, 1'b0, 1'b0); n++; end
    chk("s1_lock_latency", n, SETTLE + 7 + LOCKN);
    chk("s1_offset", bit_offset, 7);
    chk("s1_valid", data_valid, 1);
    chk("s1_aligned", aligned_data, SYNC);
    $display("scenario 1: locked after %0d cycles at offset %0d", n, bit_offset);

    // Scenario 4: realign and system reset together while locked.
    repeat (3) cyc(w7, 1'b0, 1'b0);
    cyc(w7, 1'b1, 1'b1);
    chk("s4_state", link_state, 0);
    chk("s4_valid", data_valid, 0);
    chk("s4_relock", relock_count, 1);
    $display("scenario 4: state %0d relock_count %0d", link_state, relock_count);

    // Scenario 3: corrupt one word at match 30 of verification.
    n = 0;
    while (!(m_state == 2 && m_cnt == 30) && n < 200) begin cyc(w7, 1'b0, 1'b0); n++; end
    chk("s3_at_match30", link_state, 2);
    cyc(w7 ^ 20'($urandom_range(1, 127)), 1'b0, 1'b0);
    n = 0;
    while (link_state != 3'd1 && n < 10) begin cyc(w7, 1'b0, 1'b0); n++; end
    chk("s3_back_search", link_state, 1);
    chk("s3_offset", bit_offset, 8);
    n = 0;
    while (link_state != 3'd3 && n < 400) begin cyc(w7, 1'b0, 1'b0); n++; end
    chk("s3_relock", link_state, 3);
    chk("s3_aligned", aligned_data, SYNC);
    $display("scenario 3: relocked at offset %0d", bit_offset);

    // Scenario 2: random data until timeout, then measure the soft-reset pulse.
    cyc(20'($urandom), 1'b0, 1'b1);
    n = 0;
    while ((link_state == 3'd1 || link_state == 3'd2) && n < 2000) begin
      n++;
      cyc(20'($urandom), 1'b0, ($urandom_range(0, 7) == 0));
    end
    chk("s2_search_cycles", n, TMO);
    chk("s2_state", link_state, 4);
    hi = 0; n = 0;
    while (link_state == 3'd4 && n < 100) begin
      hi += gtp_soft_reset;
      n++;
      cyc(20'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("s2_pulse_len", hi, PULSE);
    $display("scenario 2: soft reset high for %0d cycles", hi);

    // Scenario 5: asynchronous reset in the middle of RECOVER.
    n = 0;
    while (link_state != 3'd4 && n < 3000) begin cyc(20'($urandom), 1'b0, 1'b0); n++; end
    chk("s5_in_recover", link_state, 4);
    repeat (10) cyc(20'($urandom), 1'b0, 1'b0);
    chk("s5_soft_before", gtp_soft_reset, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_soft", gtp_soft_reset, 0);
    chk("s5_state", link_state, 0);
    chk("s5_offset", bit_offset, 0);
    chk("s5_valid", data_valid, 0);
    chk("s5_relock", relock_count, 0);
    chk("s5_aligned", aligned_data, 0);
    model_reset();
    @(negedge data_clk);
    reset_n = 1'b1;
    $display("scenario 5: reset mid-recover, soft reset %0d", gtp_soft_reset);

    // Scenario 6: 300 lock/realign rounds saturate the relock counter.
    for (int k = 0; k < 300; k++) begin
      n = 0;
      while (link_state != 3'd3 && n < 400) begin cyc(w7, 1'b0, 1'b0); n++; end
      chk("s6_locked", link_state, 3);
      cyc(w7, 1'b0, 1'b1);
    end
    chk("s6_relock_sat", relock_count, 255);
    $display("scenario 6: relock_count %0d after 300 realigns", relock_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
